shift_iter_unit: RTL and testbench

Iterative shift engine. It accepts one operand/amount/opcode per handshake, shifts the operand one bit per clock, and presents a held result under a valid/ready handshake. It produces the `<<`, `>>`, `>>>` and rotate results that the continuous-assignment shift checks in the ivltests shift suite compare against. Its semantics for over-range amounts match Verilog operator semantics, so a downstream comparator can check it directly against a combinational `<<`.

---
 rtl/shift_iter_unit.sv | 104 ++++++++++
 tb/tb_shift_iter_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_iter_unit.sv
// Iterative shift engine: one bit per clock, result held under valid/ready.
// Covers logical/arithmetic shifts and rotate-left with Verilog amount semantics.
module shift_iter_unit #(
   parameter int WIDTH = 4,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AW-1:0]    in_amt,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           nstate;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_step;
   logic [AW-1:0]    cnt;
   logic [1:0]       op;
   logic             take;

   assign take = (state == IDLE) && in_valid;

   // State register; reset wins over every transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   // Next-state: leave SHIFT on the step that consumes the last count.
   always_comb begin
      nstate = state;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               nstate = (in_amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == AW'(1)) begin
               nstate = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               nstate = IDLE;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   // One-bit step of the accumulator for the latched opcode.
   always_comb begin
      acc_step = acc;
      unique case (op)
         2'b00: acc_step = {acc[WIDTH-2:0], 1'b0};
         2'b01: acc_step = {1'b0, acc[WIDTH-1:1]};
         2'b10: acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
         2'b11: acc_step = {acc[WIDTH-2:0], acc[WIDTH-1]};
         default: acc_step = acc;
      endcase
   end

   // Datapath: latch on accept, step while shifting, otherwise hold result.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         cnt <= '0;
         op  <= 2'b00;
      end else if (take) begin
         acc <= in_data;
         cnt <= in_amt;
         op  <= in_op;
      end else if (state == SHIFT) begin
         acc <= acc_step;
         cnt <= cnt - AW'(1);
      end
   end

   // Outputs depend only on state, reset and held registers.
   always_comb begin
      in_ready  = (state == IDLE) && !reset;
      out_valid = (state == DONE) && !reset;
      out_data  = acc;
      out_zero  = (acc == '0);
   end

endmodule

// File: tb/tb_shift_iter_unit.sv
// Bench for shift_iter_unit: scoreboarded results against operator model.
// Checks latency, hold under backpressure, reset abort, exhaustive left shift.
module tb_shift_iter_unit;

   localparam int W  = 4;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic [AW-1:0] in_amt = '0;
   logic [1:0]    in_op = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic          out_zero;

   shift_iter_unit #(.WIDTH(W), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] d;
      int           c;
   } exp_t;

   exp_t sb[$];

   bit   auto_rdy = 1'b0;
   logic man_rdy = 1'b1;

   always @(posedge clk) begin
      #1;
      out_ready = auto_rdy ? ($urandom_range(0, 3) != 0) : man_rdy;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] d,
                                          input logic [AW-1:0] a,
                                          input logic [1:0] o);
      logic signed [W-1:0] sd;
      logic [W-1:0]        r;
      sd = d;
      r  = d;
      case (o)
         2'b00: r = d << a;
         2'b01: r = d >> a;
         2'b10: r = sd >>> a;
         default: begin
            for (int i = 0; i < int'(a); i++) r = {r[W-2:0], r[W-1]};
         end
      endcase
      return r;
   endfunction

   // Monitor: pop on each rising out_valid, check hold while it stays high.
   logic         prev_ov = 1'b0;
   logic [W-1:0] cur = '0;
   exp_t         me;

   always @(negedge clk) begin
      if (out_valid) begin
         chk("busy_rdy", {31'd0, in_ready}, 32'd0);
         if (!prev_ov) begin
            if (sb.size() == 0) begin
               chk("unexpected", 32'd1, 32'd0);
            end else begin
               me = sb.pop_front();
               chk("data", {28'd0, out_data}, {28'd0, me.d});
               chk("zero", {31'd0, out_zero}, {31'd0, (me.d == '0)});
               chk("lat", cyc, me.c);
               cur = me.d;
            end
         end else begin
            chk("hold", {28'd0, out_data}, {28'd0, cur});
         end
      end
      prev_ov = out_valid;
   end

   task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a,
                       input logic [1:0] o);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_op    = o;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_to", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      e.d = model(d, a, o);
      e.c = cyc + int'(a) + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_amt   = AW'($urandom);
      in_op    = 2'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("drain_to", 32'd0, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog");
      $fatal(1);
   end

   initial begin
      int n;
      // reset for two cycles
      @(negedge clk);
      @(negedge clk);
      chk("rst_ov", {31'd0, out_valid}, 32'd0);
      chk("rst_od", {28'd0, out_data}, 32'd0);
      chk("rst_oz", {31'd0, out_zero}, 32'd1);
      chk("rst_ir", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ir", {31'd0, in_ready}, 32'd1);
      chk("post_rst_ov", {31'd0, out_valid}, 32'd0);

      // directed cases
      send(4'h3, 4'd2, 2'b00);  drain();
      send(4'h5, 4'd0, 2'b00);  drain();
      send(4'hF, 4'd15, 2'b01); drain();
      send(4'h9, 4'd2, 2'b10);  drain();
      send(4'h9, 4'd5, 2'b11);  drain();
      send(4'h9, 4'd15, 2'b10); drain();
      send(4'h9, 4'd15, 2'b11); drain();
      send(4'h8, 4'd15, 2'b00); drain();

      // backpressure in DONE
      @(negedge clk);
      man_rdy = 1'b0;
      send(4'h6, 4'd1, 2'b00);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold", {28'd0, out_data}, 32'hC);
         chk("bp_ir", {31'd0, in_ready}, 32'd0);
         in_valid = 1'b1;
         in_data  = W'(i + 1);
         in_amt   = 4'd0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      man_rdy  = 1'b1;
      n = 0;
      while (!(out_valid && out_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_hs", {31'd0, out_valid & out_ready}, 32'd1);
      @(negedge clk);
      chk("bp_after_ir", {31'd0, in_ready}, 32'd1);
      chk("bp_after_ov", {31'd0, out_valid}, 32'd0);
      repeat (4) @(negedge clk);
      chk("idle_keep", {28'd0, out_data}, 32'hC);

      // reset after four shift steps of a ten-step request
      send(4'hA, 4'd10, 2'b00);
      repeat (4) @(posedge clk);
      #1;
      reset    = 1'b1;
      in_valid = 1'b1;
      in_amt   = 4'd3;
      in_data  = 4'h7;
      sb.delete();
      @(negedge clk);
      chk("mid_rst_ir", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("abort_od", {28'd0, out_data}, 32'd0);
      chk("abort_oz", {31'd0, out_zero}, 32'd1);
      chk("abort_ov", {31'd0, out_valid}, 32'd0);
      chk("abort_ir", {31'd0, in_ready}, 32'd1);
      repeat (15) @(negedge clk);

      // exhaustive left shift with random stalls, then random ops
      auto_rdy = 1'b1;
      for (int d = 0; d < 16; d++) begin
         for (int a = 0; a < 16; a++) begin
            send(W'(d), AW'(a), 2'b00);
         end
      end
      for (int i = 0; i < 40; i++) begin
         send(W'($urandom), AW'($urandom), 2'($urandom));
      end
      drain();
      auto_rdy = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
